// File: rtl/assoc_cache.sv
// N-way set-associative, write-back, write-allocate blocking cache with uncached word access.
// Build option ASSOC_CACHE_LRU_EN selects true LRU replacement; otherwise a free-running LFSR picks the victim.
module assoc_cache #(
    parameter int  WAYS       = 2,
    parameter int  SETS       = 256,
    parameter int  LINE_WORDS = 4,
    localparam int OFF_W      = $clog2(LINE_WORDS * 4),
    localparam int IDX_W      = $clog2(SETS),
    localparam int TAG_W      = 32 - OFF_W - IDX_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid,
    input  logic                       op,
    input  logic [IDX_W-1:0]           index,
    input  logic [TAG_W-1:0]           tag,
    input  logic [OFF_W-1:0]           offset,
    input  logic [3:0]                 wstrb,
    input  logic [31:0]                wdata,
    input  logic                       uncache,
    output logic                       addr_ok,
    output logic                       data_ok,
    output logic [31:0]                rdata,
    output logic                       rd_req,
    output logic [2:0]                 rd_type,
    output logic [31:0]                rd_addr,
    input  logic                       rd_rdy,
    input  logic                       ret_valid,
    input  logic                       ret_last,
    input  logic [31:0]                ret_data,
    output logic                       wr_req,
    output logic [2:0]                 wr_type,
    output logic [31:0]                wr_addr,
    output logic [3:0]                 wr_wstrb,
    output logic [LINE_WORDS*32-1:0]   wr_data,
    input  logic                       wr_rdy
);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int LINE_W = LINE_WORDS * 32;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REPLACE, REFILL, RESP} state_t;
    state_t state, state_nx;

    logic              req_op, req_unc;
    logic [IDX_W-1:0]  req_index;
    logic [TAG_W-1:0]  req_tag;
    logic [BEAT_W-1:0] req_word;
    logic [3:0]        req_wstrb;
    logic [31:0]       req_wdata;

    logic [TAG_W-1:0]  tag_ram  [WAYS][SETS];
    logic [LINE_W-1:0] data_ram [WAYS][SETS];
    logic [TAG_W-1:0]  tag_q    [WAYS];
    logic [LINE_W-1:0] data_q   [WAYS];
    logic [WAYS-1:0]   valid_bits [SETS];
    logic [WAYS-1:0]   dirty_bits [SETS];

    logic [LINE_W-1:0] line_buf, hit_line;
    logic [WAY_W-1:0]  way_sel, hit_way, victim_way, repl_way;
    logic [TAG_W-1:0]  victim_tag;
    logic              victim_dirty, need_wr, hit;
    logic [WAYS-1:0]   hit_vec;
    logic [BEAT_W-1:0] beat;
    logic [31:0]       word_addr;
    logic              unused_bits;

    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return res;
    endfunction

    assign unused_bits = ^offset[1:0];
    assign word_addr   = {req_tag, req_index, req_word, 2'b00};
    assign need_wr     = req_unc ? req_op : victim_dirty;
    assign hit         = |hit_vec;

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = !req_unc && valid_bits[req_index][w] && (tag_q[w] == req_tag);
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
        // Lowest-numbered invalid way wins; the policy way is used only for a full set.
        victim_way = repl_way;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_bits[req_index][w]) victim_way = WAY_W'(w);
        hit_line = data_q[hit_way];
        hit_line[32*req_word +: 32] = merge_word(data_q[hit_way][32*req_word +: 32], req_wdata, req_wstrb);
    end

`ifdef ASSOC_CACHE_LRU_EN
    logic [WAY_W-1:0] age [SETS][WAYS];
    logic             repl_upd;
    logic [WAY_W-1:0] acc_way, old_age;

    assign repl_upd = (state == LOOKUP && hit && !req_op) || (state == RESP && !req_unc);
    assign acc_way  = (state == LOOKUP) ? hit_way : way_sel;
    // A way filled from invalid counts as the oldest, so ages settle into a permutation as the set fills.
    assign old_age  = valid_bits[req_index][acc_way] ? age[req_index][acc_way] : WAY_W'(WAYS - 1);

    always_comb begin
        repl_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (age[req_index][w] == WAY_W'(WAYS - 1)) repl_way = WAY_W'(w);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) age[s][w] <= '0;
        end else if (repl_upd) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == acc_way) age[req_index][w] <= '0;
                else if (age[req_index][w] < old_age) age[req_index][w] <= age[req_index][w] + WAY_W'(1);
            end
        end
    end
`else
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign repl_way = lfsr[WAY_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        addr_ok  = 1'b0;
        data_ok  = 1'b0;
        rdata    = '0;
        rd_req   = 1'b0;
        rd_type  = 3'b100;
        rd_addr  = '0;
        wr_req   = 1'b0;
        wr_type  = 3'b100;
        wr_addr  = '0;
        wr_wstrb = '0;
        wr_data  = '0;
        if (reset) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    addr_ok = valid;
                    if (valid) state_nx = LOOKUP;
                end
                LOOKUP: begin
                    if (req_unc) begin
                        state_nx = req_op ? MISS : REPLACE;
                    end else if (hit && !req_op) begin
                        data_ok  = 1'b1;
                        rdata    = data_q[hit_way][32*req_word +: 32];
                        addr_ok  = valid;
                        state_nx = valid ? LOOKUP : IDLE;
                    end else begin
                        state_nx = hit ? RESP : MISS;
                    end
                end
                MISS: begin
                    wr_req = need_wr;
                    if (need_wr && req_unc) begin
                        wr_type  = 3'b010;
                        wr_addr  = word_addr;
                        wr_wstrb = req_wstrb;
                        wr_data  = {{(LINE_W-32){1'b0}}, req_wdata};
                    end else if (need_wr) begin
                        wr_addr = {victim_tag, req_index, {OFF_W{1'b0}}};
                        wr_data = line_buf;
                    end
                    if (!need_wr || wr_rdy) state_nx = (req_unc && req_op) ? RESP : REPLACE;
                end
                REPLACE: begin
                    rd_req  = 1'b1;
                    rd_type = req_unc ? 3'b010 : 3'b100;
                    rd_addr = req_unc ? word_addr : {req_tag, req_index, {OFF_W{1'b0}}};
                    if (rd_rdy) state_nx = REFILL;
                end
                REFILL: begin
                    if (ret_valid && ret_last) state_nx = RESP;
                end
                RESP: begin
                    data_ok  = 1'b1;
                    rdata    = req_unc ? line_buf[31:0] : line_buf[32*req_word +: 32];
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (addr_ok) begin
            req_op    <= op;
            req_unc   <= uncache;
            req_index <= index;
            req_tag   <= tag;
            req_word  <= offset[OFF_W-1:2];
            req_wstrb <= wstrb;
            req_wdata <= wdata;
            for (int w = 0; w < WAYS; w++) begin
                tag_q[w]  <= tag_ram[w][index];
                data_q[w] <= data_ram[w][index];
            end
        end
        // line_buf holds the merged hit line, or the victim line until the refill overwrites it.
        if (state == LOOKUP && !req_unc && !(hit && !req_op)) begin
            way_sel      <= hit ? hit_way : victim_way;
            victim_tag   <= tag_q[victim_way];
            victim_dirty <= !hit && valid_bits[req_index][victim_way] && dirty_bits[req_index][victim_way];
            line_buf     <= hit ? hit_line : data_q[victim_way];
        end
        if (state == REPLACE) beat <= '0;
        if (state == REFILL && ret_valid) begin
            line_buf[32*beat +: 32] <= (req_op && !req_unc && beat == req_word)
                                       ? merge_word(ret_data, req_wdata, req_wstrb) : ret_data;
            beat <= beat + BEAT_W'(1);
        end
        if (state == RESP && !req_unc && !reset) begin
            tag_ram[way_sel][req_index]  <= req_tag;
            data_ram[way_sel][req_index] <= line_buf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_bits[s] <= '0;
                dirty_bits[s] <= '0;
            end
        end else if (state == RESP && !req_unc) begin
            valid_bits[req_index][way_sel] <= 1'b1;
            dirty_bits[req_index][way_sel] <= req_op;
        end
    end
endmodule

// File: tb/tb_assoc_cache.sv
// Directed self-checking bench for assoc_cache (WAYS=4, SETS=256, LINE_WORDS=4) with a simple bus responder.
module tb_assoc_cache;
    localparam int WAYS = 4, SETS = 256, LINE_WORDS = 4;
    localparam int LW = LINE_WORDS * 32;

    logic          clk = 1'b0, reset = 1'b1;
    logic          valid = 1'b0, op = 1'b0, uncache = 1'b0;
    logic [7:0]    index = '0;
    logic [19:0]   tag = '0;
    logic [3:0]    offset = '0, wstrb = '0;
    logic [31:0]   wdata = '0;
    logic          rd_rdy = 1'b0, ret_valid = 1'b0, ret_last = 1'b0, wr_rdy = 1'b0;
    logic [31:0]   ret_data = '0;
    logic          addr_ok, data_ok, rd_req, wr_req;
    logic [31:0]   rdata, rd_addr, wr_addr;
    logic [2:0]    rd_type, wr_type;
    logic [3:0]    wr_wstrb;
    logic [LW-1:0] wr_data;

    assoc_cache #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LINE_WORDS)) dut (
        .clk(clk), .reset(reset), .valid(valid), .op(op), .index(index), .tag(tag),
        .offset(offset), .wstrb(wstrb), .wdata(wdata), .uncache(uncache),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    logic [31:0] beats [LINE_WORDS];
    int          nbeats;
    int          lat, last_cyc, n_rd, n_wr, n_dok, wr_cycles;
    bit          wr_stable, rd_before_wr;
    logic [31:0] got_rdata, wr_addr_s, wr_data_s, rd_addr_s;
    logic [2:0]  wr_type_s, rd_type_s;
    logic [3:0]  wr_wstrb_s;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", name, obs, exp);
        end
    endtask

    task automatic set_beats(input logic [31:0] b0, b1, b2, b3);
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        nbeats = 4;
    endtask

    // Issue one request and act as the bus until data_ok (or until abort_beats beats, then assert reset).
    task automatic access(input logic o, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                          input logic u, input int wr_delay, input int abort_beats);
        int  k;
        bit  refill, wr_done;
        n_rd = 0; n_wr = 0; n_dok = 0; lat = -1; last_cyc = -1; wr_cycles = 0;
        wr_stable = 1; rd_before_wr = 0; got_rdata = '0; k = 0; refill = 0; wr_done = 0;
        @(negedge clk);
        valid = 1'b1; op = o; tag = a[31:12]; index = a[11:4]; offset = a[3:0];
        wstrb = s; wdata = d; uncache = u;
        #1;
        for (int i = 0; i < 20 && !addr_ok; i++) begin @(negedge clk); #1; end
        chk("accept", 32'(addr_ok), 32'd1);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            valid = 1'b0; rd_rdy = 1'b0; wr_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
            if (refill && abort_beats >= 0 && k == abort_beats) begin
                reset = 1'b1;
                #1;
                return;
            end
            if (refill) begin
                ret_valid = 1'b1; ret_data = beats[k]; ret_last = (k == nbeats - 1);
                if (ret_last) begin refill = 0; last_cyc = cyc; end
                k++;
            end
            #1;
            if (data_ok) begin n_dok++; lat = cyc; got_rdata = rdata; break; end
            if (wr_req) begin
                if (wr_cycles == 0) begin
                    wr_addr_s = wr_addr; wr_type_s = wr_type; wr_data_s = wr_data[31:0]; wr_wstrb_s = wr_wstrb;
                end else if (wr_addr !== wr_addr_s || wr_type !== wr_type_s || wr_data[31:0] !== wr_data_s) begin
                    wr_stable = 0;
                end
                wr_cycles++;
                if (wr_cycles > wr_delay) begin wr_rdy = 1'b1; n_wr++; wr_done = 1; end
            end
            if (rd_req) begin
                if (wr_cycles > 0 && !wr_done) rd_before_wr = 1;
                rd_addr_s = rd_addr; rd_type_s = rd_type; rd_rdy = 1'b1; n_rd++; refill = 1; k = 0;
            end
        end
        chk("completed", 32'(n_dok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: every output is quiet even with a request pending.
        valid = 1'b1;
        @(negedge clk); #1;
        chk("rst_addr_ok", 32'(addr_ok), 32'd0);
        chk("rst_data_ok", 32'(data_ok), 32'd0);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rd_addr", rd_addr, 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data[31:0], 32'd0);
        chk("rst_wr_wstrb", 32'(wr_wstrb), 32'd0);
        chk("rst_rd_type", 32'(rd_type), 32'd4);
        chk("rst_wr_type", 32'(wr_type), 32'd4);
        @(negedge clk);
        reset = 1'b0; valid = 1'b0;

        // Read miss then read hit on 0x0000_1004.
        set_beats(32'h11, 32'h22, 32'h33, 32'h44);
        access(1'b0, 32'h0000_1004, 4'h0, 32'h0, 1'b0, 0, -1);
        chk("t1_rdata", got_rdata, 32'h22);
        chk("t1_rd_addr", rd_addr_s, 32'h0000_1000);
        chk("t1_rd_type", 32'(rd_type_s), 32'd4);
        chk("t1_no_wr", 32'(n_wr), 32'd0);
        chk("t1_latency", 32'(lat), 32'(last_cyc + 1));
        access(1'b0, 32'h0000_1004, 4'h0, 32'h0, 1'b0, 0, -1);
        chk("t1_hit_rdata", got_rdata, 32'h22);
        chk("t1_hit_latency", 32'(lat), 32'd1);
        chk("t1_hit_no_rd", 32'(n_rd), 32'd0);

        // Partial write hit merges bytes and dirties the line.
        set_beats(32'h1234_5678, 32'hA1, 32'hA2, 32'hA3);
        access(1'b0, 32'h0000_2000, 4'h0, 32'h0, 1'b0, 0, -1);
        chk("t2_fill_rdata", got_rdata, 32'h1234_5678);
        access(1'b1, 32'h0000_2000, 4'b0011, 32'hDEAD_BEEF, 1'b0, 0, -1);
        chk("t2_wr_latency", 32'(lat), 32'd2);
        chk("t2_wr_no_rd", 32'(n_rd), 32'd0);
        access(1'b0, 32'h0000_2000, 4'h0, 32'h0, 1'b0, 0, -1);
        chk("t2_merged", got_rdata, 32'h1234_BEEF);
        chk("t2_merged_latency", 32'(lat), 32'd1);
        chk("t2_dirty", 32'(dut.dirty_bits[0][1]), 32'd1);

        // Fill set 0 with dirty lines, then evict the least recently used one.
        set_beats(32'h30, 32'h31, 32'h32, 32'h33);
        access(1'b1, 32'h0000_3000, 4'hF, 32'h3333_3333, 1'b0, 0, -1);
        chk("t3_wmiss_rd", 32'(n_rd), 32'd1);
        set_beats(32'h40, 32'h41, 32'h42, 32'h43);
        access(1'b1, 32'h0000_4000, 4'hF, 32'h4444_4444, 1'b0, 0, -1);
        access(1'b1, 32'h0000_1000, 4'hF, 32'h0BAD_F00D, 1'b0, 0, -1);
        chk("t3_whit1_latency", 32'(lat), 32'd2);
        access(1'b1, 32'h0000_2004, 4'hF, 32'h2222_2222, 1'b0, 0, -1);
        chk("t3_whit2_latency", 32'(lat), 32'd2);
        set_beats(32'h51, 32'h52, 32'h53, 32'h54);
        access(1'b0, 32'h0000_5000, 4'h0, 32'h0, 1'b0, 0, -1);
        chk("t3_one_wb", 32'(n_wr), 32'd1);
        chk("t3_wb_type", 32'(wr_type_s), 32'd4);
        chk("t3_rd_after_wb", 32'(rd_before_wr), 32'd0);
        chk("t3_rd_addr", rd_addr_s, 32'h0000_5000);
        chk("t3_rdata", got_rdata, 32'h51);
`ifdef ASSOC_CACHE_LRU_EN
        chk("t3_wb_addr_lru", wr_addr_s, 32'h0000_3000);
        chk("t3_wb_word0", wr_data_s, 32'h3333_3333);
`else
        chk("t3_wb_addr_in_set", 32'(wr_addr_s inside {32'h1000, 32'h2000, 32'h3000, 32'h4000}), 32'd1);
`endif

        // Uncached word write bypasses the arrays.
        access(1'b1, 32'hBFAF_0000, 4'hF, 32'hCAFE_F00D, 1'b1, 0, -1);
        chk("t4_wr_type", 32'(wr_type_s), 32'd2);
        chk("t4_wr_addr", wr_addr_s, 32'hBFAF_0000);
        chk("t4_wr_data", wr_data_s, 32'hCAFE_F00D);
        chk("t4_wr_wstrb", 32'(wr_wstrb_s), 32'hF);
        chk("t4_no_rd", 32'(n_rd), 32'd0);
        chk("t4_latency", 32'(lat), 32'd3);
        set_beats(32'hB0, 32'hB1, 32'hB2, 32'hB3);
        access(1'b0, 32'hBFAF_0004, 4'h0, 32'h0, 1'b0, 0, -1);
        chk("t4_not_allocated", 32'(n_rd), 32'd1);
        chk("t4_refill_addr", rd_addr_s, 32'hBFAF_0000);
        chk("t4_refill_rdata", got_rdata, 32'hB1);

        // Uncached word read.
        beats[0] = 32'hA5A5_A5A5; nbeats = 1;
        access(1'b0, 32'h1FC0_0008, 4'h0, 32'h0, 1'b1, 0, -1);
        chk("unc_rd_type", 32'(rd_type_s), 32'd2);
        chk("unc_rd_addr", rd_addr_s, 32'h1FC0_0008);
        chk("unc_rdata", got_rdata, 32'hA5A5_A5A5);
        chk("unc_no_wr", 32'(n_wr), 32'd0);

        // Bus holds off the write for five cycles.
        access(1'b1, 32'hBFAF_0010, 4'b0101, 32'h0102_0304, 1'b1, 5, -1);
        chk("t5_wr_cycles", 32'(wr_cycles), 32'd6);
        chk("t5_wr_stable", 32'(wr_stable), 32'd1);
        chk("t5_no_rd", 32'(n_rd), 32'd0);
        chk("t5_wstrb", 32'(wr_wstrb_s), 32'h5);
        chk("t5_latency", 32'(lat), 32'd8);

        // Reset during refill abandons the access; the line must miss again afterwards.
        set_beats(32'h70, 32'h71, 32'h72, 32'h73);
        access(1'b0, 32'h0000_7008, 4'h0, 32'h0, 1'b0, 0, 2);
        chk("t6_rst_rd_req", 32'(rd_req), 32'd0);
        chk("t6_rst_data_ok", 32'(data_ok), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_idle_addr_ok", 32'(addr_ok), 32'd0);
        chk("t6_idle_rd_req", 32'(rd_req), 32'd0);
        chk("t6_idle_wr_req", 32'(wr_req), 32'd0);
        chk("t6_idle_rd_addr", rd_addr, 32'd0);
        chk("t6_idle_wr_addr", wr_addr, 32'd0);
        set_beats(32'h80, 32'h81, 32'h82, 32'h83);
        access(1'b0, 32'h0000_7008, 4'h0, 32'h0, 1'b0, 0, -1);
        chk("t6_miss_again", 32'(n_rd), 32'd1);
        chk("t6_clean_after_rst", 32'(n_wr), 32'd0);
        chk("t6_rdata", got_rdata, 32'h82);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
